pwm_update_controller: RTL

- Sequences the transducer PWM datapath.
- Owns the free-running 9-bit carrier time base shared by all pwm_generator instances.
- Holds a host-writable shadow bank of per-transducer DUTY/PHASE, plus the global DUTY_OFFSET.
- Commits the shadow bank to the active bank atomically on a carrier-period boundary, so no generator ever sees a torn duty/phase pair mid-period.

---
 rtl/pwm_ctrl_pkg.sv | 20 ++
 rtl/pwm_time_counter.sv | 36 +++
 rtl/pwm_update_controller.sv | 119 +++++++++++
 3 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and widths for the PWM update controller and its time base.
package pwm_ctrl_pkg;

    localparam int TIME_W  = 9;
    localparam int DUTY_W  = 8;
    localparam int PHASE_W = 8;

    // Commit sequencing: IDLE accepts writes, PENDING waits for a boundary.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    // One transducer's duty/phase pair, always moved as a unit.
    typedef struct packed {
        logic [DUTY_W-1:0]  duty;
        logic [PHASE_W-1:0] phase;
    } pair_t;

endpackage

// File: rtl/pwm_time_counter.sv
// Free-running carrier time base. BOUNDARY flags that the next edge returns
// TIME to 0, either by natural wrap or by an external SYNC pulse.
module pwm_time_counter
    import pwm_ctrl_pkg::*;
#(
    parameter int CYCLE = 510
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              SYNC,
    output logic [TIME_W-1:0] TIME,
    output logic              BOUNDARY
);

    localparam logic [TIME_W-1:0] LAST = TIME_W'(CYCLE - 1);

    logic [TIME_W-1:0] time_d;
    logic [TIME_W-1:0] time_q;

    // Next time value: restart at 0 on wrap or SYNC, otherwise count up.
    always_comb begin
        BOUNDARY = (time_q == LAST) || SYNC;
        time_d   = BOUNDARY ? '0 : time_q + TIME_W'(1);
    end

    // Time register.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of process ordering.
        if (!RST_N) time_q <= '0;
        else        time_q <= time_d;
    end

    assign TIME = time_q;

endmodule

// File: rtl/pwm_update_controller.sv
// Owns the carrier time base plus shadow/active duty-phase banks, and
// commits the shadow bank to the active bank atomically on a boundary.
module pwm_update_controller
    import pwm_ctrl_pkg::*;
#(
    parameter int TRANS_NUM = 249,
    parameter int CYCLE     = 510
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          SYNC,
    input  logic                          WE,
    input  logic [7:0]                    ADDR,
    input  logic [DUTY_W-1:0]             DUTY_IN,
    input  logic [PHASE_W-1:0]            PHASE_IN,
    input  logic                          OFFSET_IN,
    input  logic                          COMMIT,
    output logic                          PENDING,
    output logic                          ERR,
    output logic                          CYCLE_START,
    output logic [TIME_W-1:0]             TIME,
    output logic [DUTY_W*TRANS_NUM-1:0]   DUTY,
    output logic [PHASE_W*TRANS_NUM-1:0]  PHASE,
    output logic                          DUTY_OFFSET
);

    localparam logic [8:0] ADDR_LIMIT = 9'(TRANS_NUM);

    logic   boundary;
    logic   write_ok;
    logic   apply;

    state_e state_d, state_q;
    logic   err_d, err_q;
    logic   shadow_off_d, shadow_off_q;
    logic   active_off_d, active_off_q;
    pair_t  shadow_d [TRANS_NUM];
    pair_t  shadow_q [TRANS_NUM];
    pair_t  active_d [TRANS_NUM];
    pair_t  active_q [TRANS_NUM];

    pwm_time_counter #(.CYCLE(CYCLE)) u_time (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .SYNC     (SYNC),
        .TIME     (TIME),
        .BOUNDARY (boundary)
    );

    // FSM, write acceptance and bank next-state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d      = state_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        shadow_off_d = shadow_off_q;
        active_off_d = active_off_q;

        write_ok = WE && (state_q == ST_IDLE) && ({1'b0, ADDR} < ADDR_LIMIT);
        err_d    = WE && !write_ok;
        // A commit made in IDLE on a boundary edge waits for the next one.
        apply    = (state_q == ST_PENDING) && boundary;

        if (write_ok) begin
            shadow_d[ADDR] = '{duty: DUTY_IN, phase: PHASE_IN};
        end

        case (state_q)
            ST_IDLE: begin
                if (COMMIT) begin
                    shadow_off_d = OFFSET_IN;
                    state_d      = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // Further COMMITs are absorbed by the one already pending.
                if (apply) begin
                    active_d     = shadow_q;
                    active_off_d = shadow_off_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, error pulse and both banks.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            err_q        <= 1'b0;
            shadow_off_q <= 1'b0;
            active_off_q <= 1'b0;
            // NOTE: the banks are flop arrays with reset, not RAM; a reset
            // must leave every generator at duty 0, so they are cleared here.
            shadow_q     <= '{default: '0};
            active_q     <= '{default: '0};
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            shadow_off_q <= shadow_off_d;
            active_off_q <= active_off_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
        end
    end

    for (genvar i = 0; i < TRANS_NUM; i++) begin : g_pack
        assign DUTY[i*DUTY_W +: DUTY_W]    = active_q[i].duty;
        assign PHASE[i*PHASE_W +: PHASE_W] = active_q[i].phase;
    end

    assign PENDING     = (state_q == ST_PENDING);
    assign ERR         = err_q;
    assign CYCLE_START = (TIME == '0);
    assign DUTY_OFFSET = active_off_q;

endmodule
